// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: PC feedback, instruction-memory request/response,
// and the decode-side valid/ready head of the fetch buffer.
interface instr_fetch_unit_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] PC;
   logic [1:0]      PCSrc;
   logic            PCEn;
   logic            IMemReq;
   logic [XLEN-1:0] IMemAddr;
   logic            IMemGnt;
   logic            IMemRValid;
   logic [XLEN-1:0] IMemRData;
   logic            InstrValid;
   logic            InstrReady;
   logic [XLEN-1:0] Instr;
   logic [XLEN-1:0] InstrPC;
   logic [XLEN-1:0] InstrPCPlus4;

   modport master (
      input  PC, PCSrc, IMemGnt, IMemRValid, IMemRData, InstrReady,
      output PCEn, IMemReq, IMemAddr, InstrValid, Instr, InstrPC,
             InstrPCPlus4
   );

   modport slave (
      output PC, PCSrc, IMemGnt, IMemRValid, IMemRData, InstrReady,
      input  PCEn, IMemReq, IMemAddr, InstrValid, Instr, InstrPC,
             InstrPCPlus4
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding imem request, small FIFO of {instr, pc}
// toward decode, PC advance only on an accepted fetch or a redirect.
module instr_fetch_unit #(
   parameter int DEPTH = 2,
   parameter int XLEN  = 32
) (
   input logic                CLK,
   input logic                Reset,
   instr_fetch_unit_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic {IDLE, WAIT} state_t;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fb_entry_t;

   state_t          state_q;
   state_t          state_d;
   logic            drop_q;
   logic            drop_d;
   logic [XLEN-1:0] req_pc_q;
   logic [CW-1:0]   count_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [AW-1:0]   wr_ptr_q;
   fb_entry_t       fb_q [DEPTH];

   logic          flush;
   logic          in_wait;
   logic          resp;
   logic          issue;
   logic          grant;
   logic          push;
   logic          pop;
   logic [CW-1:0] occupancy;

   assign flush     = bus.PCSrc != 2'b00;
   assign in_wait   = state_q == WAIT;
   assign resp      = in_wait && bus.IMemRValid;
   assign occupancy = count_q + CW'(in_wait);
   assign push      = resp && !drop_q && !flush;
   assign pop       = bus.InstrValid && bus.InstrReady && !flush;

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         drop_q  <= drop_d;
      end
   end

   // A flush with the response still in flight keeps us in WAIT
   // so that the wrong-path response is swallowed when it lands.
   always_comb begin
      state_d = state_q;
      drop_d  = drop_q;
      unique case (1'b1)
         flush: begin
            state_d = (in_wait && !bus.IMemRValid) ? WAIT : IDLE;
            drop_d  = in_wait && !bus.IMemRValid;
         end
         grant: begin
            state_d = WAIT;
            drop_d  = 1'b0;
         end
         (resp && !grant && !flush): begin
            state_d = IDLE;
            drop_d  = 1'b0;
         end
         default: ;
      endcase
   end

   always_comb begin
      issue = Reset && !flush && !drop_q
              && (occupancy < DEPTH_C)
              && (!in_wait || bus.IMemRValid);
      grant        = issue && bus.IMemGnt;
      bus.IMemReq  = issue;
      bus.PCEn     = Reset && (grant || flush);
   end

   assign bus.IMemAddr = bus.PC;

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         req_pc_q <= '0;
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            fb_q[i] <= '0;
         end
      end else begin
         if (grant) begin
            req_pc_q <= bus.PC;
         end
         if (flush) begin
            count_q  <= '0;
            rd_ptr_q <= wr_ptr_q;
         end else begin
            if (push) begin
               fb_q[wr_ptr_q] <= '{instr: bus.IMemRData, pc: req_pc_q};
               wr_ptr_q       <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
               rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push != pop) begin
               count_q <= push ? count_q + CW'(1) : count_q - CW'(1);
            end
         end
      end
   end

   assign bus.InstrValid   = count_q != '0;
   assign bus.Instr        = fb_q[rd_ptr_q].instr;
   assign bus.InstrPC      = fb_q[rd_ptr_q].pc;
   assign bus.InstrPCPlus4 = fb_q[rd_ptr_q].pc + XLEN'(4);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: PC register and variable-latency imem stand-ins,
// a queue-level reference model, and directed redirect/reset scenarios.
module tb_instr_fetch_unit;
   localparam int DEPTH = 2;
   localparam int XLEN  = 32;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] p4;
   } ent_t;

   logic clk;
   logic rst_n;

   instr_fetch_unit_if #(.XLEN(XLEN)) bus ();

   instr_fetch_unit #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .CLK   (clk),
      .Reset (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   ent_t        mq[$];
   bit          m_wait;
   bit          m_wrong;
   logic [31:0] m_wpc;

   bit          chk_en;
   bit          pred_req;
   bit          obs_req;
   bit          obs_pcen;
   bit          obs_valid;
   logic [31:0] obs_pc;
   logic [31:0] obs_instr;
   logic [31:0] obs_p4;
   bit          e_fl;
   bit          e_req;
   bit          e_pcen;
   bit          e_valid;

   logic [31:0] pc_reg;
   logic [31:0] pc_target;
   int          lat;
   bit          mem_busy;
   int          mem_cnt;
   logic [31:0] mem_addr;
   ent_t        plog[$];
   logic [31:0] gq[$];
   bit          ok;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] word(input logic [31:0] a);
      logic [31:0] k;
      k = (a >> 2) + 32'd1;
      return (k << 20) | ({27'd0, k[4:0]} << 7) | 32'h13;
   endfunction

   function automatic ent_t lp(input int i);
      ent_t e;
      if (i < plog.size()) return plog[i];
      e.instr = '1;
      e.pc    = '1;
      e.p4    = '1;
      return e;
   endfunction

   function automatic logic [31:0] ga(input int i);
      if (i < gq.size()) return gq[i];
      return '1;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         e_fl    = bus.PCSrc != 2'b00;
         e_req   = rst_n && !e_fl && !m_wrong
                   && (mq.size() + (m_wait ? 1 : 0) < DEPTH)
                   && (!m_wait || bus.IMemRValid);
         e_pcen  = rst_n && ((e_req && bus.IMemGnt) || e_fl);
         e_valid = rst_n && (mq.size() > 0);
         pred_req  = e_req;
         obs_req   = bus.IMemReq;
         obs_pcen  = bus.PCEn;
         obs_valid = bus.InstrValid;
         obs_pc    = bus.InstrPC;
         obs_instr = bus.Instr;
         obs_p4    = bus.InstrPCPlus4;
         chk("IMemReq", 32'(bus.IMemReq), 32'(e_req));
         chk("PCEn", 32'(bus.PCEn), 32'(e_pcen));
         chk("InstrValid", 32'(bus.InstrValid), 32'(e_valid));
         if (e_req) chk("IMemAddr", bus.IMemAddr, bus.PC);
         if (e_valid) begin
            chk("Instr", bus.Instr, mq[0].instr);
            chk("InstrPC", bus.InstrPC, mq[0].pc);
            chk("InstrPCPlus4", bus.InstrPCPlus4, mq[0].pc + 32'd4);
         end
      end
   end

   task automatic tick();
      bit          fl;
      bit          rsp;
      logic [31:0] old_pc;
      @(posedge clk);
      fl  = bus.PCSrc != 2'b00;
      rsp = m_wait && bus.IMemRValid;
      if (!rst_n) begin
         mq.delete();
         m_wait  = 0;
         m_wrong = 0;
      end else begin
         if (fl) begin
            mq.delete();
            if (rsp) begin
               m_wait  = 0;
               m_wrong = 0;
            end else if (m_wait) begin
               m_wrong = 1;
            end
         end else begin
            if (mq.size() > 0 && bus.InstrReady) void'(mq.pop_front());
            if (rsp) begin
               if (!m_wrong)
                  mq.push_back('{bus.IMemRData, m_wpc, m_wpc + 32'd4});
               m_wait  = 0;
               m_wrong = 0;
            end
         end
         if (pred_req && bus.IMemGnt) begin
            m_wait = 1;
            m_wpc  = bus.PC;
         end
      end
      if (rst_n && obs_valid && bus.InstrReady && !fl)
         plog.push_back('{obs_instr, obs_pc, obs_p4});
      old_pc = pc_reg;
      if (!rst_n) begin
         pc_reg   = 32'h0;
         mem_busy = 0;
      end else begin
         if (obs_pcen) pc_reg = fl ? pc_target : pc_reg + 32'd4;
         if (mem_busy) begin
            if (mem_cnt == 1) mem_busy = 0;
            else mem_cnt--;
         end
         if (obs_req && bus.IMemGnt) begin
            mem_busy = 1;
            mem_cnt  = lat;
            mem_addr = old_pc;
            gq.push_back(old_pc);
         end
      end
      #1;
      bus.PC         = pc_reg;
      bus.IMemRValid = mem_busy && (mem_cnt == 1);
      bus.IMemRData  = bus.IMemRValid ? word(mem_addr) : 32'hBAD0BAD0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      tick();
      tick();
      rst_n = 1'b1;
      plog.delete();
      gq.delete();
   endtask

   initial begin
      rst_n          = 1'b1;
      chk_en         = 0;
      pc_reg         = 32'h0;
      pc_target      = 32'h0;
      lat            = 1;
      mem_busy       = 0;
      mem_cnt        = 0;
      mem_addr       = 32'h0;
      bus.PC         = 32'h0;
      bus.PCSrc      = 2'b00;
      bus.IMemGnt    = 1'b1;
      bus.IMemRValid = 1'b0;
      bus.IMemRData  = 32'h0;
      bus.InstrReady = 1'b1;
      #1;
      rst_n  = 1'b0;
      chk_en = 1;
      #1;
      chk("rst_req", 32'(bus.IMemReq), 32'd0);
      chk("rst_pcen", 32'(bus.PCEn), 32'd0);
      chk("rst_valid", 32'(bus.InstrValid), 32'd0);
      chk("rst_instr", bus.Instr, 32'h0);
      chk("rst_pc", bus.InstrPC, 32'h0);
      chk("rst_pc4", bus.InstrPCPlus4, 32'h4);
      tick();
      tick();
      rst_n = 1'b1;
      plog.delete();
      gq.delete();
      #1;
      chk("rel_req", 32'(bus.IMemReq), 32'd1);
      chk("rel_addr", bus.IMemAddr, 32'h0);

      repeat (8) tick();
      chk("str_pc0", lp(0).pc, 32'h0);
      chk("str_pc1", lp(1).pc, 32'h4);
      chk("str_pc2", lp(2).pc, 32'h8);
      chk("str_p4_0", lp(0).p4, 32'h4);
      chk("str_p4_1", lp(1).p4, 32'h8);
      chk("str_p4_2", lp(2).p4, 32'hC);
      chk("str_i0", lp(0).instr, 32'h00100093);
      chk("str_i1", lp(1).instr, 32'h00200113);

      bus.InstrReady = 1'b0;
      do_reset();
      repeat (6) tick();
      #1;
      chk("bp_req", 32'(bus.IMemReq), 32'd0);
      chk("bp_pcen", 32'(bus.PCEn), 32'd0);
      chk("bp_valid", 32'(bus.InstrValid), 32'd1);
      chk("bp_head", bus.InstrPC, 32'h0);
      chk("bp_addr", bus.IMemAddr, 32'h8);
      tick();
      #1;
      chk("bp_held", bus.IMemAddr, 32'h8);
      bus.InstrReady = 1'b1;
      repeat (8) tick();
      chk("bp_d0", lp(0).pc, 32'h0);
      chk("bp_d1", lp(1).pc, 32'h4);
      chk("bp_d2", lp(2).pc, 32'h8);

      lat = 4;
      ok  = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (mem_busy && mem_cnt >= 2) begin
            ok = 1;
            break;
         end
      end
      chk("rd1_setup_timeout", 32'(ok), 32'd1);
      pc_target = 32'h50;
      bus.PCSrc = 2'b01;
      #1;
      tick();
      bus.PCSrc = 2'b00;
      lat       = 1;
      plog.delete();
      gq.delete();
      repeat (12) tick();
      chk("rd1_addr", ga(0), 32'h50);
      chk("rd1_pc", lp(0).pc, 32'h50);
      chk("rd1_instr", lp(0).instr, 32'h01500A93);

      ok = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (bus.IMemRValid) begin
            ok = 1;
            break;
         end
      end
      chk("rd2_setup_timeout", 32'(ok), 32'd1);
      pc_target = 32'h100;
      bus.PCSrc = 2'b10;
      #1;
      tick();
      bus.PCSrc = 2'b00;
      plog.delete();
      gq.delete();
      #1;
      chk("rd2_valid", 32'(bus.InstrValid), 32'd0);
      repeat (6) tick();
      chk("rd2_addr", ga(0), 32'h100);
      chk("rd2_pc", lp(0).pc, 32'h100);

      lat = 3;
      ok  = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (bus.InstrValid && mem_busy && mem_cnt >= 2) begin
            ok = 1;
            break;
         end
      end
      chk("mr_setup_timeout", 32'(ok), 32'd1);
      rst_n       = 1'b0;
      bus.IMemGnt = 1'b0;
      #1;
      chk("mr_valid", 32'(bus.InstrValid), 32'd0);
      chk("mr_req", 32'(bus.IMemReq), 32'd0);
      chk("mr_pcen", 32'(bus.PCEn), 32'd0);
      tick();
      tick();
      rst_n          = 1'b1;
      bus.IMemRValid = 1'b1;
      bus.IMemRData  = 32'hDEADBEEF;
      #1;
      chk("mr_stray_req", 32'(bus.IMemReq), 32'd1);
      chk("mr_stray_pcen", 32'(bus.PCEn), 32'd0);
      tick();
      bus.IMemGnt = 1'b1;
      lat         = 1;
      plog.delete();
      gq.delete();
      repeat (6) tick();
      chk("mr_addr", ga(0), 32'h0);
      chk("mr_pc", lp(0).pc, 32'h0);
      chk("mr_instr", lp(0).instr, 32'h00100093);

      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
